// File: rtl/alu_4bit.sv
// alu_4bit: registered WIDTH-bit ALU acting as a single-cycle execute stage.
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset, clears all outputs
//   A, B      - unsigned operands
//   sel       - operation select (ADD, SUB, AND, OR, XOR, NAND, NOR, XNOR)
//   in_valid  - qualifies A/B/sel in the current cycle
//   result    - registered result
//   Cout      - registered carry (ADD) / borrow (SUB), 0 for logic ops
//   zero      - registered, 1 when result is all zeros
//   out_valid - registered, 1 for the cycle after an accepted request
module alu_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             Cout,
  output logic             zero,
  output logic             out_valid
);

  localparam int unsigned EXT_W = WIDTH + 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NAND = 3'b101,
    OP_NOR  = 3'b110,
    OP_XNOR = 3'b111
  } op_e;

  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  logic [EXT_W-1:0] sum;
  logic [EXT_W-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;

  // Operation decode; all eight encodings are legal.
  always_comb begin
    // The extra top bit holds the carry for ADD and the borrow for SUB
    // (it goes high exactly when the zero-extended difference wraps, i.e. A < B).
    sum      = EXT_W'(A) + EXT_W'(B);
    diff     = EXT_W'(A) - EXT_W'(B);
    alu_res  = '0;
    alu_cout = 1'b0;
    case (op_e'(sel))
      OP_ADD:  begin alu_res = sum[WIDTH-1:0];  alu_cout = sum[WIDTH];  end
      OP_SUB:  begin alu_res = diff[WIDTH-1:0]; alu_cout = diff[WIDTH]; end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NAND: alu_res = ~(A & B);
      OP_NOR:  alu_res = ~(A | B);
      OP_XNOR: alu_res = ~(A ^ B);
      default: ;
    endcase
  end

  // Next-state: capture on a valid request, otherwise hold and drop out_valid.
  always_comb begin
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    if (in_valid) begin
      result_d = alu_res;
      cout_d   = alu_cout;
      zero_d   = (alu_res == '0);
      valid_d  = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign result    = result_q;
  assign Cout      = cout_q;
  assign zero      = zero_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit: directed self-checking bench for alu_4bit.
module tb_alu_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] sel;
  logic       in_valid;
  logic [3:0] result;
  logic       Cout;
  logic       zero;
  logic       out_valid;

  int n_cmp;
  int n_fail;

  // Observed output bundle: {out_valid, Cout, zero, result}.
  logic [6:0] obs;
  assign obs = {out_valid, Cout, zero, result};

  alu_4bit #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .sel      (sel),
    .in_valid (in_valid),
    .result   (result),
    .Cout     (Cout),
    .zero     (zero),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent arithmetic reference: returns {Cout, zero, result}.
  function automatic logic [5:0] ref_model(input logic [2:0] s, input int a, input int b);
    int r;
    int c;
    c = 0;
    case (s)
      3'd0: begin r = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
      3'd1: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = 15 - (a & b);
      3'd6: r = 15 - (a | b);
      default: r = 15 - (a ^ b);
    endcase
    ref_model = {c[0], (r == 0), r[3:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    A = 4'($urandom_range(0, 15));
    B = 4'($urandom_range(0, 15));
    sel = 3'($urandom_range(0, 7));
    #1;
    n_cmp++;
    if (obs !== 7'b000_0000) begin
      n_fail++;
      $display("FAIL reset_immediate: got %b, required %b", obs, 7'b000_0000);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      A = 4'($urandom_range(0, 15));
      B = 4'($urandom_range(0, 15));
      sel = 3'($urandom_range(0, 7));
      n_cmp++;
      if (obs !== 7'b000_0000) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b, required %b", i, obs, 7'b000_0000);
      end
    end
    rst = 1'b0;
    sel = 3'b000; A = 4'b0010; B = 4'b0011; in_valid = 1'b1;
    tick();
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 1'b0, 4'b0101}) begin
      n_fail++;
      $display("FAIL reset_first_req: got %b, required %b", obs, {1'b1, 1'b0, 1'b0, 4'b0101});
    end
  endtask

  task automatic test_arith();
    logic [2:0] v_sel [4];
    logic [3:0] v_a   [4];
    logic [3:0] v_b   [4];
    logic [6:0] v_exp [4];
    v_sel[0] = 3'b000; v_a[0] = 4'b1010; v_b[0] = 4'b0101; v_exp[0] = {1'b1, 1'b0, 1'b0, 4'b1111};
    v_sel[1] = 3'b000; v_a[1] = 4'b1111; v_b[1] = 4'b0001; v_exp[1] = {1'b1, 1'b1, 1'b1, 4'b0000};
    v_sel[2] = 3'b001; v_a[2] = 4'b1100; v_b[2] = 4'b0011; v_exp[2] = {1'b1, 1'b0, 1'b0, 4'b1001};
    v_sel[3] = 3'b001; v_a[3] = 4'b0000; v_b[3] = 4'b0001; v_exp[3] = {1'b1, 1'b1, 1'b0, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      sel = v_sel[i]; A = v_a[i]; B = v_b[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (obs !== v_exp[i]) begin
        n_fail++;
        $display("FAIL arith[%0d]: got %b, required %b", i, obs, v_exp[i]);
      end
      tick();
    end
    // SUB with equal operands.
    sel = 3'b001; A = 4'b0110; B = 4'b0110; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL sub_equal: got %b, required %b", obs, {1'b1, 1'b0, 1'b1, 4'b0000});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] v_sel [6];
    logic [3:0] v_a   [6];
    logic [3:0] v_b   [6];
    logic [6:0] v_exp [6];
    v_sel[0] = 3'b010; v_a[0] = 4'b1010; v_b[0] = 4'b0101; v_exp[0] = {1'b1, 1'b0, 1'b1, 4'b0000};
    v_sel[1] = 3'b011; v_a[1] = 4'b1111; v_b[1] = 4'b0000; v_exp[1] = {1'b1, 1'b0, 1'b0, 4'b1111};
    v_sel[2] = 3'b100; v_a[2] = 4'b1010; v_b[2] = 4'b1100; v_exp[2] = {1'b1, 1'b0, 1'b0, 4'b0110};
    v_sel[3] = 3'b101; v_a[3] = 4'b1100; v_b[3] = 4'b1010; v_exp[3] = {1'b1, 1'b0, 1'b0, 4'b0111};
    v_sel[4] = 3'b110; v_a[4] = 4'b1100; v_b[4] = 4'b1010; v_exp[4] = {1'b1, 1'b0, 1'b0, 4'b0001};
    v_sel[5] = 3'b111; v_a[5] = 4'b1100; v_b[5] = 4'b1010; v_exp[5] = {1'b1, 1'b0, 1'b0, 4'b1001};
    in_valid = 1'b1;
    sel = v_sel[0]; A = v_a[0]; B = v_b[0];
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 5) begin
        sel = v_sel[i+1]; A = v_a[i+1]; B = v_b[i+1];
      end else begin
        in_valid = 1'b0;
      end
      n_cmp++;
      if (obs !== v_exp[i]) begin
        n_fail++;
        $display("FAIL logic_b2b[%0d]: got %b, required %b", i, obs, v_exp[i]);
      end
    end
  endtask

  task automatic test_hold();
    sel = 3'b000; A = 4'b0011; B = 4'b0100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 1'b0, 4'b0111}) begin
      n_fail++;
      $display("FAIL hold_issue: got %b, required %b", obs, {1'b1, 1'b0, 1'b0, 4'b0111});
    end
    for (int i = 0; i < 3; i++) begin
      A = 4'($urandom_range(0, 15));
      B = 4'($urandom_range(0, 15));
      sel = (i == 1) ? 3'bxxx : 3'($urandom_range(0, 7));
      tick();
      n_cmp++;
      if (obs !== {1'b0, 1'b0, 1'b0, 4'b0111}) begin
        n_fail++;
        $display("FAIL hold[%0d]: got %b, required %b", i, obs, {1'b0, 1'b0, 1'b0, 4'b0111});
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 3'b001; A = 4'b1100; B = 4'b0011; in_valid = 1'b1;
    tick();
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 1'b0, 4'b1001}) begin
      n_fail++;
      $display("FAIL rstmid_pre: got %b, required %b", obs, {1'b1, 1'b0, 1'b0, 4'b1001});
    end
    // Request pending while reset is asserted between edges.
    sel = 3'b000; A = 4'b0001; B = 4'b0001; in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 7'b000_0000) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b, required %b", obs, 7'b000_0000);
    end
    tick();
    n_cmp++;
    if (obs !== 7'b000_0000) begin
      n_fail++;
      $display("FAIL rstmid_edge: got %b, required %b", obs, 7'b000_0000);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (obs !== 7'b000_0000) begin
      n_fail++;
      $display("FAIL rstmid_discard: got %b, required %b", obs, 7'b000_0000);
    end
  endtask

  task automatic test_exhaustive();
    logic [5:0] exp;
    int         errs;
    errs = 0;
    in_valid = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          sel = 3'(s); A = 4'(a); B = 4'(b);
          exp = ref_model(3'(s), a, b);
          tick();
          n_cmp++;
          if (obs !== {1'b1, exp}) begin
            n_fail++;
            errs++;
            if (errs <= 10)
              $display("FAIL exhaustive sel=%0d A=%0d B=%0d: got %b, required %b",
                       s, a, b, obs, {1'b1, exp});
          end
        end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    sel = '0;
    #3;
    test_reset();
    test_arith();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
